hyperram_req_ctrl: RTL and testbench
====================================

# hyperram_req_ctrl

Request sequencer directly upstream of the HyperRAM bus interface. It accepts valid/ready burst read and write requests from user logic and stages write data in a local FIFO. It issues one `ctrl_cs` strobe per request and feeds write words on `ctrl_wr_data_next`. It counts returned read words and enforces an inter-transaction gap, so user logic never has to track interface timing.

## Interface
- `FIFO_DEPTH`, 16: write-data FIFO depth in 32-bit words; power of two; also the maximum burst length.
- `GAP_CYCLES`, 4: idle cycles after a transaction completes before the next `ctrl_cs`; range 1–15.
- `DEF_LATENCY`, 3'd6: value driven on `ctrl_latency`.
- `clk` in 1: system clock, the same clock as the bus interface.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_reg` in 1: 1 = register space, 0 = memory.
- `req_addr` in 32: word address.
- `req_len` in 8: burst length in words; 0 is treated as 1; values above `FIFO_DEPTH` are clamped to `FIFO_DEPTH`.
- `wdata_valid` in 1, `wdata_ready` out 1, `wdata` in 32: write-data stream.
- `rdata_valid` out 1, `rdata` out 32, `rdata_last` out 1: read-data stream; no backpressure.
- `done` out 1: one-cycle pulse when a transaction completes.
- `err` out 1: one-cycle timeout pulse; see Configuration.
- `ctrl_cs`, `ctrl_rd_sel`, `ctrl_wr_sel`, `ctrl_mem_sel`, `ctrl_reg_sel` out 1 each: command to the bus interface.
- `ctrl_num_words` out 8, `ctrl_latency` out 3, `ctrl_addr_in` out 32, `ctrl_wr_data_in` out 32: command fields to the bus interface.
- `ctrl_wr_data_next` in 1: the bus interface consumed the current write word.
- `ctrl_rd_data_out` in 32, `ctrl_rd_data_valid` in 1: read words returned by the bus interface.

## Operation
- FSM states: IDLE, FILL, ISSUE, WAIT_RD, WAIT_WR, GAP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch the request and compute `len_q` = clamp(`req_len`).
  - A read goes to ISSUE. A write goes to FILL.
- **FILL**
  - Stay until FIFO count ≥ `len_q`, then go to ISSUE.
  - `wdata_ready` = FIFO not full. It is independent of state, so write data may be pushed ahead of its request.
- **ISSUE**
  - `ctrl_cs`=1 for exactly one cycle. All `ctrl_*` command fields are valid in that cycle and stay held until the next ISSUE.
  - `ctrl_rd_sel` = !write, `ctrl_wr_sel` = write, `ctrl_reg_sel` = `req_reg`, `ctrl_mem_sel` = !`req_reg`, `ctrl_num_words` = `len_q`.
  - A read goes to WAIT_RD. A write goes to WAIT_WR.
- **WAIT_RD**
  - Each `ctrl_rd_data_valid` cycle forwards `ctrl_rd_data_out` to `rdata` with `rdata_valid`, one-cycle registered.
  - The beat counter decrements on each word. The `len_q`-th word asserts `rdata_last` and moves to GAP.
- **WAIT_WR**
  - `ctrl_wr_data_in` = FIFO head, combinational.
  - Each `ctrl_wr_data_next` cycle pops the FIFO and decrements the counter.
  - The last pop moves to GAP.
  - Register writes (`req_reg`=1) use `len_q`=1.
- **GAP**
  - Count `GAP_CYCLES`, pulse `done` on entry, then return to IDLE.
- All outputs reset to 0, the FSM resets to IDLE, and the FIFO resets empty.

## Timing
- `req_valid` and `req_ready` both high at edge N: a read has `ctrl_cs` high in cycle N+1.
- A write issues one cycle after the FIFO count reaches `len_q`.
- Read data: `ctrl_rd_data_valid` at edge M gives `rdata_valid` in cycle M+1.
- Minimum spacing between two `ctrl_cs` strobes is 1 + `GAP_CYCLES` + 1 cycles after completion.
- FIFO push and pop in the same cycle leave the count unchanged. A push while full is ignored; `wdata_ready` is 0 then.
- `ctrl_wr_data_next` while the FIFO is empty: hold the counter and set sticky status bit `underrun_q`, which is visible in simulation only.
- `ctrl_rd_data_valid` outside WAIT_RD is dropped.
- `rst_n` low mid-burst: immediate return to IDLE, FIFO flushed, `ctrl_cs`=0, no `done`.

## Configuration
- `HRAM_REQ_TIMEOUT_EN`
  - **Defined:** a 12-bit watchdog runs in WAIT_RD and WAIT_WR and is reset on every beat. At 4095 cycles with no beat: pulse `err`, flush the FIFO, go to GAP, and suppress `done`.
  - **Undefined:** `err` is tied to 0, there is no counter, and the wait states wait indefinitely.

## Structure
- Shared package `hyperram_pkg`:
  - state enum `hram_req_state_t`
  - constant `HRAM_MAX_BURST`=16
  - constant `HRAM_DEF_LATENCY`=3'd6
  - constant `HRAM_TIMEOUT_MAX`=12'hFFF
- Sub-module `hyperram_wr_fifo`: synchronous FIFO, 32-bit, `FIFO_DEPTH` deep, with count output and first-word-fall-through head.

## Test plan
- Read, `req_addr`=0x100, `req_len`=4: one `ctrl_cs` with `ctrl_addr_in`=0x100 and `ctrl_num_words`=4; four injected words 0xA0..0xA3 appear on `rdata` in order, with `rdata_last` on 0xA3; `done` pulses after that.
- Write, `req_len`=3, data pushed before the request: `ctrl_cs` follows with `ctrl_wr_data_in`=D0; on the next pulses it presents D1 and D2; FIFO is empty at `done`.
- Write request first, data trickled in 1 word per 5 cycles, `req_len`=2: `ctrl_cs` does not fire until the 2nd word is pushed.
- `req_len`=0 gives `ctrl_num_words`=1. `req_len`=40 gives `ctrl_num_words`=16.
- Back-to-back requests with `GAP_CYCLES`=4: second `ctrl_cs` appears no earlier than 6 cycles after the first completion.
- `rst_n` pulsed low after 2 of 8 read words: outputs return to 0 and no `done` pulses. With `HRAM_REQ_TIMEOUT_EN` defined, withholding read data gives `err` after 4095 cycles.

Source files
------------

// File: rtl/hyperram_pkg.sv
// Shared types and constants for the HyperRAM request sequencer.
package hyperram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    ISSUE   = 3'd2,
    WAIT_RD = 3'd3,
    WAIT_WR = 3'd4,
    GAP     = 3'd5
  } hram_req_state_t;

  localparam int          HRAM_MAX_BURST   = 16;
  localparam logic [2:0]  HRAM_DEF_LATENCY = 3'd6;
  localparam logic [11:0] HRAM_TIMEOUT_MAX = 12'hFFF;

  // Burst length as the bus sees it: zero means one word, anything past the FIFO is capped.
  function automatic logic [7:0] hram_clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    logic [7:0] res;
    if (len == 8'd0) begin
      res = 8'd1;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/hyperram_wr_fifo.sv
// Write-data staging FIFO: 32-bit words, first-word-fall-through head, occupancy count.
module hyperram_wr_fifo
  import hyperram_pkg::*;
#(
  parameter int DEPTH = HRAM_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [31:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer and count update; a push while full and a pop while empty are both ignored.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/hyperram_req_ctrl.sv
// Request sequencer in front of the HyperRAM bus interface: accepts burst requests,
// stages write data, strobes ctrl_cs once per request, counts read beats and enforces
// an idle gap between transactions.
// Optional read/write watchdog: define HRAM_REQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a request
// FILL    | write accepted, waiting for enough words in the FIFO
// ISSUE   | one-cycle ctrl_cs with command fields valid
// WAIT_RD | forwarding returned read words, counting beats
// WAIT_WR | popping write words on ctrl_wr_data_next
// GAP     | done pulse, then GAP_CYCLES idle cycles before IDLE
module hyperram_req_ctrl
  import hyperram_pkg::*;
#(
  parameter int         FIFO_DEPTH  = HRAM_MAX_BURST,
  parameter int         GAP_CYCLES  = 4,
  parameter logic [2:0] DEF_LATENCY = HRAM_DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_reg,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        done,
  output logic        err,
  output logic        ctrl_cs,
  output logic        ctrl_rd_sel,
  output logic        ctrl_wr_sel,
  output logic        ctrl_mem_sel,
  output logic        ctrl_reg_sel,
  output logic [7:0]  ctrl_num_words,
  output logic [2:0]  ctrl_latency,
  output logic [31:0] ctrl_addr_in,
  output logic [31:0] ctrl_wr_data_in,
  input  logic        ctrl_wr_data_next,
  input  logic [31:0] ctrl_rd_data_out,
  input  logic        ctrl_rd_data_valid
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] MAX_LEN  = 8'(FIFO_DEPTH);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  hram_req_state_t state_q, state_d;

  logic [7:0]  len_q, len_d;
  logic        write_q, write_d;
  logic        reg_q, reg_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  beat_q, beat_d;
  logic [3:0]  gap_q, gap_d;

  logic        cmd_rd_q, cmd_rd_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic        cmd_mem_q, cmd_mem_d;
  logic        cmd_reg_q, cmd_reg_d;
  logic [7:0]  cmd_words_q, cmd_words_d;
  logic [2:0]  cmd_lat_q, cmd_lat_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;

  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        rdata_last_q, rdata_last_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;

  logic        load_cmd;
  logic        beat_seen;

  logic          fifo_pop, fifo_flush;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

`ifdef HRAM_REQ_TIMEOUT_EN
  logic [11:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  hyperram_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_wr_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (fifo_flush),
    .push     (wdata_valid),
    .push_data(wdata),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign req_ready       = (state_q == IDLE);
  assign wdata_ready     = !fifo_full;
  assign ctrl_cs         = (state_q == ISSUE);
  assign ctrl_rd_sel     = cmd_rd_q;
  assign ctrl_wr_sel     = cmd_wr_q;
  assign ctrl_mem_sel    = cmd_mem_q;
  assign ctrl_reg_sel    = cmd_reg_q;
  assign ctrl_num_words  = cmd_words_q;
  assign ctrl_latency    = cmd_lat_q;
  assign ctrl_addr_in    = cmd_addr_q;
  // Stale storage is never shown on the bus; an empty FIFO presents zero.
  assign ctrl_wr_data_in = fifo_empty ? 32'd0 : fifo_head;
  assign rdata           = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign rdata_last      = rdata_last_q;
  assign done            = done_q;
`ifdef HRAM_REQ_TIMEOUT_EN
  assign err             = err_q;
`else
  assign err             = 1'b0;
`endif

  // Next-state and datapath logic for the request sequencer.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    write_d       = write_q;
    reg_d         = reg_q;
    addr_d        = addr_q;
    beat_d        = beat_q;
    gap_d         = gap_q;
    cmd_rd_d      = cmd_rd_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_mem_d     = cmd_mem_q;
    cmd_reg_d     = cmd_reg_q;
    cmd_words_d   = cmd_words_q;
    cmd_lat_d     = cmd_lat_q;
    cmd_addr_d    = cmd_addr_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    rdata_last_d  = 1'b0;
    done_d        = 1'b0;
    underrun_d    = underrun_q;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    load_cmd      = 1'b0;
    beat_seen     = 1'b0;
`ifdef HRAM_REQ_TIMEOUT_EN
    wd_d          = wd_q;
    err_d         = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          reg_d    = req_reg;
          addr_d   = req_addr;
          len_d    = (req_write && req_reg) ? 8'd1 : hram_clamp_len(req_len, MAX_LEN);
          state_d  = req_write ? FILL : ISSUE;
          load_cmd = !req_write;
        end
      end
      FILL: begin
        if (8'(fifo_count) >= len_q) begin
          state_d  = ISSUE;
          load_cmd = 1'b1;
        end
      end
      ISSUE: begin
        beat_d  = len_q;
        state_d = write_q ? WAIT_WR : WAIT_RD;
`ifdef HRAM_REQ_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      WAIT_RD: begin
        if (ctrl_rd_data_valid) begin
          beat_seen     = 1'b1;
          rdata_valid_d = 1'b1;
          rdata_d       = ctrl_rd_data_out;
          if (beat_q == 8'd1) begin
            rdata_last_d = 1'b1;
            done_d       = 1'b1;
            gap_d        = GAP_LOAD;
            state_d      = GAP;
          end else begin
            beat_d = beat_q - 8'd1;
          end
        end
      end
      WAIT_WR: begin
        if (ctrl_wr_data_next) begin
          if (fifo_empty) begin
            underrun_d = 1'b1;
          end else begin
            beat_seen = 1'b1;
            fifo_pop  = 1'b1;
            if (beat_q == 8'd1) begin
              done_d  = 1'b1;
              gap_d   = GAP_LOAD;
              state_d = GAP;
            end else begin
              beat_d = beat_q - 8'd1;
            end
          end
        end
      end
      GAP: begin
        // The done cycle plus GAP_CYCLES quiet cycles precede the return to IDLE.
        if (gap_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef HRAM_REQ_TIMEOUT_EN
    if (state_q == WAIT_RD || state_q == WAIT_WR) begin
      if (beat_seen) begin
        wd_d = '0;
      end else if (wd_q == HRAM_TIMEOUT_MAX) begin
        err_d      = 1'b1;
        fifo_flush = 1'b1;
        gap_d      = GAP_LOAD;
        state_d    = GAP;
      end else begin
        wd_d = wd_q + 12'd1;
      end
    end
`endif

    // Command fields are captured on the way into ISSUE and held until the next one.
    if (load_cmd) begin
      cmd_rd_d    = !write_d;
      cmd_wr_d    = write_d;
      cmd_reg_d   = reg_d;
      cmd_mem_d   = !reg_d;
      cmd_words_d = len_d;
      cmd_lat_d   = DEF_LATENCY;
      cmd_addr_d  = addr_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      write_q       <= 1'b0;
      reg_q         <= 1'b0;
      addr_q        <= '0;
      beat_q        <= '0;
      gap_q         <= '0;
      cmd_rd_q      <= 1'b0;
      cmd_wr_q      <= 1'b0;
      cmd_mem_q     <= 1'b0;
      cmd_reg_q     <= 1'b0;
      cmd_words_q   <= '0;
      cmd_lat_q     <= '0;
      cmd_addr_q    <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      done_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      write_q       <= write_d;
      reg_q         <= reg_d;
      addr_q        <= addr_d;
      beat_q        <= beat_d;
      gap_q         <= gap_d;
      cmd_rd_q      <= cmd_rd_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_mem_q     <= cmd_mem_d;
      cmd_reg_q     <= cmd_reg_d;
      cmd_words_q   <= cmd_words_d;
      cmd_lat_q     <= cmd_lat_d;
      cmd_addr_q    <= cmd_addr_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_last_q  <= rdata_last_d;
      done_q        <= done_d;
      underrun_q    <= underrun_d;
    end
  end

`ifdef HRAM_REQ_TIMEOUT_EN
  // Watchdog counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_hyperram_req_ctrl.sv
// Self-checking bench for hyperram_req_ctrl: directed scenarios plus a randomized
// sequence, all checked against a transaction-level model (clamp rule, word queues).
module tb_hyperram_req_ctrl;

  localparam int DEPTH = 16;
  localparam int GAPC  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_write = 1'b0, req_reg = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid, rdata_last, done, err;
  logic [31:0] rdata;
  logic        ctrl_cs, ctrl_rd_sel, ctrl_wr_sel, ctrl_mem_sel, ctrl_reg_sel;
  logic [7:0]  ctrl_num_words;
  logic [2:0]  ctrl_latency;
  logic [31:0] ctrl_addr_in, ctrl_wr_data_in;
  logic        ctrl_wr_data_next = 1'b0;
  logic [31:0] ctrl_rd_data_out = '0;
  logic        ctrl_rd_data_valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  logic [31:0] wq[$];

  hyperram_req_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAPC),
    .DEF_LATENCY(3'd6)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_reg           (req_reg),
    .req_addr          (req_addr),
    .req_len           (req_len),
    .wdata_valid       (wdata_valid),
    .wdata_ready       (wdata_ready),
    .wdata             (wdata),
    .rdata_valid       (rdata_valid),
    .rdata             (rdata),
    .rdata_last        (rdata_last),
    .done              (done),
    .err               (err),
    .ctrl_cs           (ctrl_cs),
    .ctrl_rd_sel       (ctrl_rd_sel),
    .ctrl_wr_sel       (ctrl_wr_sel),
    .ctrl_mem_sel      (ctrl_mem_sel),
    .ctrl_reg_sel      (ctrl_reg_sel),
    .ctrl_num_words    (ctrl_num_words),
    .ctrl_latency      (ctrl_latency),
    .ctrl_addr_in      (ctrl_addr_in),
    .ctrl_wr_data_in   (ctrl_wr_data_in),
    .ctrl_wr_data_next (ctrl_wr_data_next),
    .ctrl_rd_data_out  (ctrl_rd_data_out),
    .ctrl_rd_data_valid(ctrl_rd_data_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Burst length the bus should see for a request.
  function automatic int exp_len(input bit wr, input bit rg, input int len);
    if (wr && rg) return 1;
    if (len == 0) return 1;
    if (len > DEPTH) return DEPTH;
    return len;
  endfunction

  task automatic push_word(input logic [31:0] d);
    wdata_valid = 1'b1;
    wdata       = d;
    chk("wdata_ready", 32'(wdata_ready), 32'(wq.size() < DEPTH));
    if (wq.size() < DEPTH) wq.push_back(d);
    step();
    wdata_valid = 1'b0;
  endtask

  task automatic send_req(input bit wr, input bit rg, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_reg   = rg;
    req_addr  = addr;
    req_len   = len;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic chk_issue(input bit wr, input bit rg, input logic [31:0] addr, input int e);
    chk("cs",        32'(ctrl_cs), 32'd1);
    chk("addr",      ctrl_addr_in, addr);
    chk("num_words", 32'(ctrl_num_words), 32'(e));
    chk("rd_sel",    32'(ctrl_rd_sel), 32'(!wr));
    chk("wr_sel",    32'(ctrl_wr_sel), 32'(wr));
    chk("reg_sel",   32'(ctrl_reg_sel), 32'(rg));
    chk("mem_sel",   32'(ctrl_mem_sel), 32'(!rg));
    chk("latency",   32'(ctrl_latency), 32'd6);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input bit rg,
                         input bit fixed, input logic [31:0] base, input bit spacing);
    int e;
    int gaps;
    logic [31:0] w;
    e = exp_len(1'b0, rg, len);
    send_req(1'b0, rg, addr, 8'(len));
    if (spacing) chk("cs_spacing", 32'((cyc - last_done_cyc) >= (GAPC + 2)), 32'd1);
    chk_issue(1'b0, rg, addr, e);
    step();
    chk("cs_one_cycle", 32'(ctrl_cs), 32'd0);
    for (int i = 0; i < e; i++) begin
      gaps = $urandom_range(0, 2);
      for (int k = 0; k < gaps; k++) begin
        step();
        chk("rdata_idle", 32'(rdata_valid), 32'd0);
      end
      w = fixed ? base + 32'(i) : $urandom;
      ctrl_rd_data_valid = 1'b1;
      ctrl_rd_data_out   = w;
      step();
      ctrl_rd_data_valid = 1'b0;
      chk("rdata_valid", 32'(rdata_valid), 32'd1);
      chk("rdata",       rdata, w);
      chk("rdata_last",  32'(rdata_last), 32'(i == e - 1));
      chk("rd_done",     32'(done), 32'(i == e - 1));
    end
    last_done_cyc = cyc;
  endtask

  // mode 0: data first, mode 1: request first with data every 5 cycles, mode 2: FIFO preloaded
  task automatic do_write(input logic [31:0] addr, input int len, input bit rg, input int mode);
    int e;
    int gaps;
    e = exp_len(1'b1, rg, len);
    if (mode == 0) begin
      for (int i = 0; i < e; i++) push_word($urandom);
      send_req(1'b1, rg, addr, 8'(len));
    end else if (mode == 1) begin
      send_req(1'b1, rg, addr, 8'(len));
      for (int i = 0; i < e; i++) begin
        for (int k = 0; k < 4; k++) begin
          chk("cs_early", 32'(ctrl_cs), 32'd0);
          step();
        end
        push_word($urandom);
      end
    end else begin
      send_req(1'b1, rg, addr, 8'(len));
    end
    chk("cs_fill", 32'(ctrl_cs), 32'd0);
    step();
    chk_issue(1'b1, rg, addr, e);
    chk("wr_head0", ctrl_wr_data_in, wq[0]);
    step();
    chk("cs_one_cycle", 32'(ctrl_cs), 32'd0);
    for (int i = 0; i < e; i++) begin
      gaps = $urandom_range(0, 2);
      for (int k = 0; k < gaps; k++) step();
      chk("wr_head", ctrl_wr_data_in, wq[0]);
      ctrl_wr_data_next = 1'b1;
      step();
      ctrl_wr_data_next = 1'b0;
      void'(wq.pop_front());
      chk("wr_done", 32'(done), 32'(i == e - 1));
    end
    chk("fifo_empty_at_done", 32'(dut.fifo_count), 32'd0);
    last_done_cyc = cyc;
  endtask

  initial begin
    int wr;
    int rg;
    int len;
    int waited;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs",        32'(ctrl_cs), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_rvalid",    32'(rdata_valid), 32'd0);
    chk("rst_rlast",     32'(rdata_last), 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    chk("rst_num_words", 32'(ctrl_num_words), 32'd0);
    chk("rst_latency",   32'(ctrl_latency), 32'd0);
    chk("rst_addr",      ctrl_addr_in, 32'd0);
    chk("rst_sel",       32'({ctrl_rd_sel, ctrl_wr_sel, ctrl_mem_sel, ctrl_reg_sel}), 32'd0);
    chk("rst_wdata_in",  ctrl_wr_data_in, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_req_ready",   32'(req_ready), 32'd1);
    chk("idle_wdata_ready", 32'(wdata_ready), 32'd1);

    // Read data arriving while idle must be dropped.
    ctrl_rd_data_valid = 1'b1;
    ctrl_rd_data_out   = 32'hDEAD_BEEF;
    step();
    ctrl_rd_data_valid = 1'b0;
    chk("drop_idle_rdata", 32'(rdata_valid), 32'd0);

    do_read(32'h100, 4, 1'b0, 1'b1, 32'hA0, 1'b0);
    do_read($urandom, 5, 1'b0, 1'b0, 32'd0, 1'b1);
    do_write($urandom, 3, 1'b0, 0);
    do_write($urandom, 2, 1'b0, 1);
    do_read($urandom, 0, 1'b0, 1'b0, 32'd0, 1'b1);
    do_read($urandom, 40, 1'b0, 1'b0, 32'd0, 1'b1);

    for (int i = 0; i < DEPTH + 1; i++) push_word($urandom);
    do_write($urandom, 40, 1'b0, 2);
    do_write($urandom, 7, 1'b1, 0);
    do_read($urandom, 3, 1'b1, 1'b0, 32'd0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      wr  = $urandom_range(0, 1);
      rg  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      len = $urandom_range(0, 24);
      if (wr != 0) do_write($urandom, len, rg[0], $urandom_range(0, 1));
      else         do_read($urandom, len, rg[0], 1'b0, 32'd0, 1'b1);
    end

    // Reset in the middle of an 8-word read with a word parked in the FIFO.
    push_word($urandom);
    send_req(1'b0, 1'b0, 32'h2000, 8'd8);
    chk_issue(1'b0, 1'b0, 32'h2000, 8);
    step();
    for (int i = 0; i < 2; i++) begin
      ctrl_rd_data_valid = 1'b1;
      ctrl_rd_data_out   = 32'hB0 + 32'(i);
      step();
      ctrl_rd_data_valid = 1'b0;
      chk("mid_rdata", rdata, 32'hB0 + 32'(i));
    end
    rst_n = 1'b0;
    #1;
    wq.delete();
    chk("mid_rst_cs",     32'(ctrl_cs), 32'd0);
    chk("mid_rst_rvalid", 32'(rdata_valid), 32'd0);
    chk("mid_rst_done",   32'(done), 32'd0);
    chk("mid_rst_words",  32'(ctrl_num_words), 32'd0);
    chk("mid_rst_fifo",   32'(dut.fifo_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_no_done", 32'(done | ctrl_cs), 32'd0);
    end
    last_done_cyc = -100;
    do_read($urandom, 1, 1'b0, 1'b0, 32'd0, 1'b0);

`ifdef HRAM_REQ_TIMEOUT_EN
    // Withhold read data: the watchdog must fire instead of done.
    send_req(1'b0, 1'b0, 32'h300, 8'd2);
    chk("to_cs", 32'(ctrl_cs), 32'd1);
    waited = 0;
    while (!err && waited < 5000) begin
      step();
      waited++;
      if (done) chk("to_no_done", 32'(done), 32'd0);
    end
    chk("to_err_seen", 32'(err), 32'd1);
    chk("to_err_time", 32'(waited >= 4095 && waited <= 4100), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("to_after_no_done", 32'(done | err), 32'd0);
    end
`else
    waited = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (err) waited++;
    end
    chk("err_tied_low", 32'(waited), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
